// File: rtl/core_interface_mc.sv
// core_interface_mc: bridges the host command bus (instruction/address/value)
// to one compute core. Holds TOTAL_INPUTS operand registers and TOTAL_OUTPUTS
// result registers, launches the core with a start/done handshake guarded by
// a timeout, and can stream the result registers round-robin.
module core_interface_mc #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 24,
    parameter int TOTAL_INPUTS   = 2,
    parameter int TOTAL_OUTPUTS  = 1,
    parameter int START_ADDRESS  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                instr_valid_i,
    output logic                                instr_ready_o,
    input  logic [7:0]                          instruction_i,
    input  logic [ADDR_WIDTH-1:0]               address_i,
    input  logic [DATA_WIDTH-1:0]               value_i,
    output logic [DATA_WIDTH-1:0]               result_o,
    output logic                                result_valid_o,
    output logic [DATA_WIDTH-1:0]               stream_o,
    output logic                                stream_valid_o,
    output logic                                done_o,
    output logic                                err_o,
    output logic [TOTAL_INPUTS*DATA_WIDTH-1:0]  core_inputs_o,
    output logic                                core_start_o,
    input  logic [TOTAL_OUTPUTS*DATA_WIDTH-1:0] core_outputs_i,
    input  logic                                core_done_i
);

    localparam logic [7:0] OP_NOP          = 8'h00;
    localparam logic [7:0] OP_WRITE        = 8'h01;
    localparam logic [7:0] OP_READ         = 8'h02;
    localparam logic [7:0] OP_RUN          = 8'h03;
    localparam logic [7:0] OP_STREAM_START = 8'h04;
    localparam logic [7:0] OP_STREAM_STOP  = 8'h05;

    localparam int IW = (TOTAL_INPUTS > 1) ? $clog2(TOTAL_INPUTS) : 1;
    localparam int OW = (TOTAL_OUTPUTS > 1) ? $clog2(TOTAL_OUTPUTS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_WAIT = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] in_regs  [TOTAL_INPUTS];
    logic [DATA_WIDTH-1:0] out_regs [TOTAL_OUTPUTS];

    logic          live_q;      // goes high on the first edge after reset
    logic [TW-1:0] tmo_q;       // RUN_WAIT cycles elapsed
    logic [OW-1:0] stream_idx;  // result register being streamed

    logic accept;
    logic op_write, op_read, op_run, op_sstart, op_sstop, op_bad;
    logic [ADDR_WIDTH-1:0] offset, out_off;
    logic [IW-1:0] in_idx;
    logic [OW-1:0] out_idx;
    logic above_base, addr_in, addr_out;
    logic [DATA_WIDTH-1:0] read_data;
    logic timeout_hit, run_done, err_d, start_d;

    assign instr_ready_o = live_q && (state_q != ST_RUN_WAIT);
    assign accept        = instr_valid_i && instr_ready_o;

    // Address window: operands first, then the read-only results.
    assign offset     = address_i - ADDR_WIDTH'(START_ADDRESS);
    assign out_off    = offset - ADDR_WIDTH'(TOTAL_INPUTS);
    assign above_base = (address_i >= ADDR_WIDTH'(START_ADDRESS));
    assign addr_in    = above_base && (offset < ADDR_WIDTH'(TOTAL_INPUTS));
    assign addr_out   = above_base && !addr_in &&
                        (offset < ADDR_WIDTH'(TOTAL_INPUTS + TOTAL_OUTPUTS));
    assign in_idx     = offset[IW-1:0];
    assign out_idx    = out_off[OW-1:0];

    assign run_done    = (state_q == ST_RUN_WAIT) && core_done_i;
    assign timeout_hit = (state_q == ST_RUN_WAIT) &&
                         (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    assign stream_valid_o = (state_q == ST_STREAM);
    assign stream_o       = stream_valid_o ? out_regs[stream_idx] : '0;

    for (genvar g = 0; g < TOTAL_INPUTS; g++) begin : g_pack
        assign core_inputs_o[g*DATA_WIDTH +: DATA_WIDTH] = in_regs[g];
    end

    // Opcode decode; anything outside the known set is flagged bad.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        op_write  = 1'b0;
        op_read   = 1'b0;
        op_run    = 1'b0;
        op_sstart = 1'b0;
        op_sstop  = 1'b0;
        op_bad    = 1'b0;
        case (instruction_i)
            OP_NOP:          ;
            OP_WRITE:        op_write  = 1'b1;
            OP_READ:         op_read   = 1'b1;
            OP_RUN:          op_run    = 1'b1;
            OP_STREAM_START: op_sstart = 1'b1;
            OP_STREAM_STOP:  op_sstop  = 1'b1;
            default:         op_bad    = 1'b1;
        endcase
    end

    // Read mux: operands, then results, zero when out of range.
    always_comb begin
        read_data = '0;
        if (addr_in) begin
            read_data = in_regs[in_idx];
        end else if (addr_out) begin
            read_data = out_regs[out_idx];
        end
    end

    // Next state, error and start decisions; a done beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_run) begin
                    state_d = ST_RUN_WAIT;
                    start_d = 1'b1;
                end else if (accept && op_sstart) begin
                    state_d = ST_STREAM;
                end
            end
            ST_RUN_WAIT: begin
                if (run_done || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept && op_sstop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            if (op_bad || (op_write && !addr_in) ||
                (op_read && !(addr_in || addr_out)) ||
                ((state_q == ST_STREAM) && (op_run || op_sstart))) begin
                err_d = 1'b1;
            end
        end
        if (timeout_hit && !core_done_i) begin
            err_d = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered host/core pulses, read data, timeout counter and stream index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
            done_o         <= 1'b0;
            core_start_o   <= 1'b0;
            tmo_q          <= '0;
            stream_idx     <= '0;
        end else begin
            live_q         <= 1'b1;
            result_valid_o <= accept && op_read;
            if (accept && op_read) begin
                result_o <= read_data;
            end
            err_o        <= err_d;
            done_o       <= run_done;
            core_start_o <= start_d;
            tmo_q        <= ((state_q == ST_RUN_WAIT) && (state_d == ST_RUN_WAIT)) ?
                            tmo_q + TW'(1) : '0;
            if ((state_q == ST_STREAM) && (state_d == ST_STREAM)) begin
                stream_idx <= (stream_idx == OW'(TOTAL_OUTPUTS - 1)) ? '0 : stream_idx + OW'(1);
            end else begin
                stream_idx <= '0;
            end
        end
    end

    // Operand writes from the host and result capture from the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: these register arrays are reset explicitly because their reset value is architecturally visible.
        if (!rst_ni) begin
            for (int i = 0; i < TOTAL_INPUTS; i++) begin
                in_regs[i] <= '0;
            end
            for (int i = 0; i < TOTAL_OUTPUTS; i++) begin
                out_regs[i] <= '0;
            end
        end else begin
            if (accept && op_write && addr_in) begin
                in_regs[in_idx] <= value_i;
            end
            if (run_done) begin
                for (int i = 0; i < TOTAL_OUTPUTS; i++) begin
                    out_regs[i] <= core_outputs_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: doc/core_interface_mc.md
Name: core_interface_mc

Overview:
Parametrised multi-channel successor to core_interface. Bridges the host command bus (instruction/address/value) to a compute core with TOTAL_INPUTS operand registers and TOTAL_OUTPUTS result registers. Adds a valid/ready command handshake, a start/done core handshake with timeout, and a continuous round-robin streaming mode. Sits between the comms decoder and one generated core.

Parameters:
DATA_WIDTH, 32, width of value, result, stream and each core operand/result
ADDR_WIDTH, 24, width of address_i
TOTAL_INPUTS, 2, number of core operand registers (>=1)
TOTAL_OUTPUTS, 1, number of core result registers (>=1)
START_ADDRESS, 0, base of the block's address window
TIMEOUT_CYCLES, 1024, maximum RUN_WAIT cycles before abort (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
instr_valid_i  in  1  command present
instr_ready_o  out  1  command accepted when valid&ready
instruction_i  in  8  opcode
address_i  in  ADDR_WIDTH  register address
value_i  in  DATA_WIDTH  write data
result_o  out  DATA_WIDTH  READ data
result_valid_o  out  1  one-cycle pulse with result_o
stream_o  out  DATA_WIDTH  streamed result word
stream_valid_o  out  1  stream_o valid
done_o  out  1  one-cycle pulse, RUN completed
err_o  out  1  one-cycle pulse, command error or timeout
core_inputs_o  out  TOTAL_INPUTS*DATA_WIDTH  operand regs, index 0 in LSBs
core_start_o  out  1  one-cycle start pulse
core_outputs_i  in  TOTAL_OUTPUTS*DATA_WIDTH  core results
core_done_i  in  1  core result valid

Behaviour:
- Address map: inputs START_ADDRESS..+TOTAL_INPUTS-1 (R/W); outputs next TOTAL_OUTPUTS addresses (RO); anything else is out of range.
- Opcodes: 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 RUN, 0x04 STREAM_START, 0x05 STREAM_STOP; any other opcode -> err_o, no state change.
- Reset (async, any state): all registers, counters and outputs 0, state IDLE. Mid-RUN or mid-stream it aborts immediately. instr_ready_o is 1 after the first edge out of reset.
- States: IDLE, RUN_WAIT, STREAM. instr_ready_o = (state != RUN_WAIT).
- WRITE to an input address: register updated at the accepting edge and visible on core_inputs_o the next cycle. WRITE to an output or out-of-range address: ignored, err_o.
- READ: result_o/result_valid_o are registered and appear the cycle after accept (latency 1). An out-of-range READ returns 0 with result_valid_o=1 and err_o=1. result_o holds its value between reads.
- RUN in IDLE: core_start_o=1 for exactly the cycle after accept; state -> RUN_WAIT; timeout counter cleared.
- In RUN_WAIT, on core_done_i=1: core_outputs_i latched into the output regs, done_o pulses next cycle, state -> IDLE.
- If TIMEOUT_CYCLES elapse without core_done_i: err_o pulses, output regs unchanged, state -> IDLE.
- core_done_i and timeout on the same cycle: done wins.
- core_done_i outside RUN_WAIT: ignored.
- STREAM_START in IDLE: state -> STREAM. From the next cycle, stream_valid_o=1 and stream_o = output reg[k], with k starting at 0, incrementing each cycle and wrapping TOTAL_OUTPUTS-1 -> 0. With TOTAL_OUTPUTS=1 the stream repeats reg[0].
- In STREAM: WRITE and READ behave as in IDLE; RUN and STREAM_START -> err_o, ignored; STREAM_STOP -> IDLE, stream_valid_o=0 the next cycle, k reset to 0.
- STREAM_STOP in IDLE: no-op, no error.
- Commands with instr_valid_i=0 have no effect. The command accept and the core_done_i capture in the same cycle are independent.

Test Plan:
- Reset mid-RUN_WAIT (rst_ni low 3 cycles) -> all outputs 0, state IDLE, instr_ready_o=1 the following cycle.
- WRITE addr0=5, addr1=7; RUN; adder model asserts core_done_i 3 cycles later with 12 -> core_start_o pulse 1 cycle, instr_ready_o=0 while waiting, done_o pulse; READ addr2 -> result_o=12, result_valid_o 1 cycle.
- RUN with core never done, TIMEOUT_CYCLES=16 -> err_o pulse 16 cycles after start, previous output (12) still read back at addr2.
- TOTAL_OUTPUTS=3, outputs {1,2,3}; STREAM_START -> stream_o 1,2,3,1,2… each cycle; WRITE addr0=9 during stream accepted; STREAM_STOP -> stream_valid_o low next cycle.
- WRITE addr2 (output) and READ addr 0x00FFFF -> err_o each, no register change, read returns 0; opcode 0x7F -> err_o only.
- RUN issued while in STREAM -> err_o, core_start_o stays 0, streaming continues uninterrupted.
